// File: rtl/adc_spi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : adc_spi_rx
//  Description : Serial front-end for a 12-bit SPI ADC. Starts a conversion on
//                every sample tick, clocks in a 16-bit frame (4 leading zeros
//                + 12 data bits, MSB first), publishes good samples with a
//                one-cycle data_valid strobe and flags malformed frames and
//                sample-tick overruns.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_rx #(
  parameter int CLK_DIV    = 2,   // clk cycles per SCLK half-period
  parameter int CS_SETUP   = 2,   // clk cycles from CS fall to first SCLK fall
  parameter int SAMPLE_DIV = 100  // clk cycles between conversion starts
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_sdo,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [11:0] x,
  output logic        data_valid,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMR_W   = $clog2(SAMPLE_DIV);

  localparam logic [TMR_W-1:0] c_tmr_last  = TMR_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] c_setup_end = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] c_half_end  = CNT_W'(CLK_DIV - 1);
  localparam logic [3:0]       c_last_bit  = 4'd15;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_setup = 2'd1;
  localparam logic [1:0] c_st_shift = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [15:0]      shift_q, shift_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic [11:0]      x_q, x_d;
  logic             dv_q, dv_d;
  logic             fe_q, fe_d;
  logic             ov_q, ov_d;
  logic             busy_q, busy_d;
  logic             tick;

  // Next-state logic: sample timer, frame sequencer and output strobes
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    x_d     = x_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;

    // Timer only runs while enabled so the first start lands SAMPLE_DIV
    // cycles after enable rises; a tick with enable low never starts a frame.
    tick = enable && (timer_q == c_tmr_last);
    if (enable) begin
      timer_d = (timer_q == c_tmr_last) ? '0 : timer_q + TMR_W'(1);
    end else begin
      timer_d = '0;
    end

    // A tick that cannot be serviced is dropped and reported.
    ov_d = tick && (state_q != c_st_idle);

    case (state_q)
      c_st_idle: begin
        if (tick) begin
          state_d = c_st_setup;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
        end
      end
      c_st_setup: begin
        if (cnt_q == c_setup_end) begin
          state_d = c_st_shift;
          cnt_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      c_st_shift: begin
        if (cnt_q == c_half_end) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Rising SCLK edge: ADC data has been stable since the fall.
            sclk_d  = 1'b1;
            shift_d = {shift_q[14:0], adc_sdo};
          end else if (bit_q == c_last_bit) begin
            // Last high phase finished; the frame is fully captured.
            state_d = c_st_done;
            if (shift_q[15:12] == 4'h0) begin
              x_d  = shift_q[11:0];
              dv_d = 1'b1;
            end else begin
              fe_d = 1'b1;
            end
          end else begin
            bit_d  = bit_q + 4'd1;
            sclk_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      c_st_done: begin
        state_d = c_st_idle;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase

    // Chip select and busy are registered from the next state so they line
    // up exactly with the state they describe.
    cs_n_d = !((state_d == c_st_setup) || (state_d == c_st_shift));
    busy_d = (state_d != c_st_idle);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_st_idle;
      timer_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      x_q     <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      x_q     <= x_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
    end
  end

  assign adc_cs_n   = cs_n_q;
  assign adc_sclk   = sclk_q;
  assign x          = x_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire
